bus_decoder: RTL and testbench

Address decoder and wait-state generator between `cpu_top` and the board memory and I/O devices. It turns the CPU's 22-bit address, `mem_io`, and active-low `rd`/`wr` strobes into active-low chip selects for BIOS ROM, BIOS RAM, external memory and eight I/O slots. A per-region wait-state counter drives `pin_wait` back into the CPU, stretching each access by a fixed number of clocks. It also flags illegal bus cycles where both strobes are low.

---
 rtl/bus_decoder_if.sv | 24 ++
 rtl/bus_decoder.sv | 99 +++++++++
 tb/tb_bus_decoder.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/bus_decoder_if.sv
// CPU-side bus bundle for bus_decoder: address, cycle type, strobes, and the
// decoded selects / wait / error returned to the CPU.
interface bus_decoder_if;
  logic [21:0] address_bus;
  logic        mem_io;
  logic        rd;
  logic        wr;
  logic        bios_rom_cs;
  logic        bios_ram_cs;
  logic        ext_mem_cs;
  logic [7:0]  io_cs;
  logic        pin_wait;
  logic        bus_err;

  modport master (
    output address_bus, mem_io, rd, wr,
    input  bios_rom_cs, bios_ram_cs, ext_mem_cs, io_cs, pin_wait, bus_err
  );

  modport slave (
    input  address_bus, mem_io, rd, wr,
    output bios_rom_cs, bios_ram_cs, ext_mem_cs, io_cs, pin_wait, bus_err
  );
endinterface

// File: rtl/bus_decoder.sv
// Address decoder and per-region wait-state generator: active-low chip selects
// for ROM/RAM/external memory/eight I/O slots, pin_wait back to the CPU, bus_err on rd&wr.
module bus_decoder #(
  parameter int unsigned ROM_WS = 2,
  parameter int unsigned RAM_WS = 0,
  parameter int unsigned EXT_WS = 3,
  parameter int unsigned IO_WS  = 1
) (
  input  logic           clk,
  input  logic           arst_n,
  bus_decoder_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       illegal_q, illegal_d;
  logic       bus_err_q, bus_err_d;

  logic       strb;
  logic       illegal;
  logic       rom_hit, ram_hit, ext_hit, io_hit;
  logic       sel_en;
  logic [3:0] ws;
  logic       pin_wait;

  always_comb begin
    strb    = (~bus.rd) ^ (~bus.wr);
    illegal = (~bus.rd) & (~bus.wr);
    rom_hit = bus.mem_io && (bus.address_bus[21:15] == 7'd0);
    ram_hit = bus.mem_io && (bus.address_bus[21:15] == 7'd1);
    ext_hit = bus.mem_io && !rom_hit && !ram_hit;
    io_hit  = !bus.mem_io && (bus.address_bus[21:7] == 15'd0);
    ws = 4'd0;
    if (rom_hit)      ws = 4'(ROM_WS);
    else if (ram_hit) ws = 4'(RAM_WS);
    else if (ext_hit) ws = 4'(EXT_WS);
    else if (io_hit)  ws = 4'(IO_WS);
    // Reset blanks every select and the wait request without waiting for a clock.
    sel_en = strb & arst_n;
  end

  assign bus.bios_rom_cs = ~(sel_en & rom_hit);
  assign bus.bios_ram_cs = ~(sel_en & ram_hit);
  assign bus.ext_mem_cs  = ~(sel_en & ext_hit);
  assign bus.io_cs       = (sel_en & io_hit) ? ~(8'd1 << bus.address_bus[6:4]) : 8'hFF;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    illegal_d = illegal;
    bus_err_d = illegal & ~illegal_q;
    pin_wait  = 1'b0;
    if (illegal) begin
      state_d = DONE;
    end else begin
      unique case (state_q)
        IDLE: begin
          pin_wait = strb & (ws != 4'd0);
          if (strb && ws != 4'd0) begin
            state_d = WAIT;
            cnt_d   = ws - 4'd1;
          end else if (strb) begin
            state_d = DONE;
          end
        end
        WAIT: begin
          pin_wait = strb & (cnt_q != 4'd0);
          if (!strb)               state_d = IDLE;
          else if (cnt_q == 4'd0)  state_d = DONE;
          else                     cnt_d   = cnt_q - 4'd1;
        end
        DONE: begin
          if (!strb) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign bus.pin_wait = pin_wait & arst_n;
  assign bus.bus_err  = bus_err_q;

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q   <= IDLE;
      cnt_q     <= 4'd0;
      illegal_q <= 1'b0;
      bus_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      illegal_q <= illegal_d;
      bus_err_q <= bus_err_d;
    end
  end

endmodule

// File: tb/tb_bus_decoder.sv
// Directed bench for bus_decoder: each stimulus cycle queues its hand-computed
// expected outputs, and an independent monitor pops and compares on the falling edge.
module tb_bus_decoder;

  localparam logic [2:0] SEL_NONE = 3'd0;
  localparam logic [2:0] SEL_ROM  = 3'd1;
  localparam logic [2:0] SEL_RAM  = 3'd2;
  localparam logic [2:0] SEL_EXT  = 3'd3;
  localparam logic [2:0] SEL_IO   = 3'd4;

  typedef struct {
    string       name;
    logic [12:0] exp;
  } exp_t;

  logic clk;
  logic arst_n;
  exp_t sb_q[$];
  int   total;
  int   bad;
  bit   stim_done;

  bus_decoder_if bus_if ();

  bus_decoder dut (
    .clk    (clk),
    .arst_n (arst_n),
    .bus    (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [12:0] exp);
    logic [12:0] act;
    act = {bus_if.bios_rom_cs, bus_if.bios_ram_cs, bus_if.ext_mem_cs,
           bus_if.io_cs, bus_if.pin_wait, bus_if.bus_err};
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got rom/ram/ext/io/wait/err=%b want %b", name, act, exp);
    end
  endtask

  // One bus cycle: drive just after the rising edge, queue what the falling edge must show.
  task automatic applyStimulus(input string name, input logic rst_v, input logic [21:0] addr,
                               input logic mio, input logic rd_v, input logic wr_v,
                               input logic [2:0] sel, input logic [2:0] idx,
                               input logic pw, input logic be);
    exp_t e;
    logic [7:0] io_exp;
    @(posedge clk);
    #1;
    arst_n             = rst_v;
    bus_if.address_bus = addr;
    bus_if.mem_io      = mio;
    bus_if.rd          = rd_v;
    bus_if.wr          = wr_v;
    io_exp = (sel == SEL_IO) ? ~(8'd1 << idx) : 8'hFF;
    e.name = name;
    e.exp  = {sel != SEL_ROM, sel != SEL_RAM, sel != SEL_EXT, io_exp, pw, be};
    sb_q.push_back(e);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        checkOutput(e.name, e.exp);
      end
    end
  end

  initial begin : stimulus
    total     = 0;
    bad       = 0;
    stim_done = 0;
    arst_n             = 1'b0;
    bus_if.address_bus = 22'h0;
    bus_if.mem_io      = 1'b1;
    bus_if.rd          = 1'b1;
    bus_if.wr          = 1'b1;

    applyStimulus("reset_idle",   0, 22'h000000, 1, 1, 1, SEL_NONE, 0, 0, 0);
    applyStimulus("reset_rd_low", 0, 22'h000010, 1, 0, 1, SEL_NONE, 0, 0, 0);
    applyStimulus("release",      1, 22'h000010, 1, 1, 1, SEL_NONE, 0, 0, 0);

    applyStimulus("rom_c0",   1, 22'h000010, 1, 0, 1, SEL_ROM,  0, 1, 0);
    applyStimulus("rom_c1",   1, 22'h000010, 1, 0, 1, SEL_ROM,  0, 1, 0);
    applyStimulus("rom_c2",   1, 22'h000010, 1, 0, 1, SEL_ROM,  0, 0, 0);
    applyStimulus("rom_done", 1, 22'h000010, 1, 0, 1, SEL_ROM,  0, 0, 0);
    applyStimulus("rom_end",  1, 22'h000010, 1, 1, 1, SEL_NONE, 0, 0, 0);

    applyStimulus("ram_c0",   1, 22'h008000, 1, 1, 0, SEL_RAM,  0, 0, 0);
    applyStimulus("ram_done", 1, 22'h008000, 1, 1, 0, SEL_RAM,  0, 0, 0);
    applyStimulus("ram_end",  1, 22'h008000, 1, 1, 1, SEL_NONE, 0, 0, 0);

    applyStimulus("io5_c0",   1, 22'h000050, 0, 0, 1, SEL_IO,   5, 1, 0);
    applyStimulus("io5_c1",   1, 22'h000050, 0, 0, 1, SEL_IO,   5, 0, 0);
    applyStimulus("io5_end",  1, 22'h000050, 0, 1, 1, SEL_NONE, 0, 0, 0);
    applyStimulus("io_unmap0",1, 22'h000080, 0, 0, 1, SEL_NONE, 0, 0, 0);
    applyStimulus("io_unmap1",1, 22'h000080, 0, 0, 1, SEL_NONE, 0, 0, 0);
    applyStimulus("io_unmapE",1, 22'h000080, 0, 1, 1, SEL_NONE, 0, 0, 0);
    applyStimulus("io0_wr_c0",1, 22'h000000, 0, 1, 0, SEL_IO,   0, 1, 0);
    applyStimulus("io0_wr_c1",1, 22'h000000, 0, 1, 0, SEL_IO,   0, 0, 0);
    applyStimulus("io0_end",  1, 22'h000000, 0, 1, 1, SEL_NONE, 0, 0, 0);

    applyStimulus("ext_c0",    1, 22'h3F0000, 1, 0, 1, SEL_EXT,  0, 1, 0);
    applyStimulus("ext_abort", 1, 22'h3F0000, 1, 1, 1, SEL_NONE, 0, 0, 0);
    applyStimulus("ext2_c0",   1, 22'h3F0000, 1, 0, 1, SEL_EXT,  0, 1, 0);
    applyStimulus("ext2_c1",   1, 22'h3F0000, 1, 0, 1, SEL_EXT,  0, 1, 0);
    applyStimulus("ext2_c2",   1, 22'h3F0000, 1, 0, 1, SEL_EXT,  0, 1, 0);
    applyStimulus("ext2_c3",   1, 22'h3F0000, 1, 0, 1, SEL_EXT,  0, 0, 0);
    applyStimulus("ext2_done", 1, 22'h3F0000, 1, 0, 1, SEL_EXT,  0, 0, 0);
    applyStimulus("ext2_end",  1, 22'h3F0000, 1, 1, 1, SEL_NONE, 0, 0, 0);

    applyStimulus("ram_top",    1, 22'h00FFFF, 1, 1, 0, SEL_RAM,  0, 0, 0);
    applyStimulus("redecode",   1, 22'h010000, 1, 1, 0, SEL_EXT,  0, 0, 0);
    applyStimulus("redec_end",  1, 22'h010000, 1, 1, 1, SEL_NONE, 0, 0, 0);

    applyStimulus("illegal_c0", 1, 22'h000010, 1, 0, 0, SEL_NONE, 0, 0, 0);
    applyStimulus("illegal_c1", 1, 22'h000010, 1, 0, 0, SEL_NONE, 0, 0, 1);
    applyStimulus("illegal_c2", 1, 22'h000010, 1, 0, 0, SEL_NONE, 0, 0, 0);
    applyStimulus("illegal_end",1, 22'h000010, 1, 1, 1, SEL_NONE, 0, 0, 0);

    applyStimulus("rst_rom_c0",  1, 22'h000010, 1, 0, 1, SEL_ROM,  0, 1, 0);
    applyStimulus("rst_mid",     0, 22'h000010, 1, 0, 1, SEL_NONE, 0, 0, 0);
    applyStimulus("rst_fresh_0", 1, 22'h000010, 1, 0, 1, SEL_ROM,  0, 1, 0);
    applyStimulus("rst_fresh_1", 1, 22'h000010, 1, 0, 1, SEL_ROM,  0, 1, 0);
    applyStimulus("rst_fresh_2", 1, 22'h000010, 1, 0, 1, SEL_ROM,  0, 0, 0);
    applyStimulus("rst_done",    1, 22'h000010, 1, 0, 1, SEL_ROM,  0, 0, 0);
    applyStimulus("rst_end",     1, 22'h000010, 1, 1, 1, SEL_NONE, 0, 0, 0);

    stim_done = 1;
    for (int i = 0; i < 5 && sb_q.size() > 0; i++) @(negedge clk);
    #1;
    total++;
    if (sb_q.size() != 0) begin
      bad++;
      $display("[TB] FAIL scoreboard_drain: got %0d pending want 0", sb_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin : watchdog
    #100000;
    $display("[TB] FAIL watchdog: got timeout want finish");
    $fatal(1, "[TB] timeout");
  end

endmodule
